// File: rtl/mem_arbiter_if.sv
// Fetch / load-store / memory bus bundle for mem_arbiter.
// slave is the arbiter's view; master is the core-and-memory side.
interface mem_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [WIDTH-1:0]      if_rdata_o;
    logic                  ls_req_i;
    logic                  ls_we_i;
    logic [ADDR_WIDTH-1:0] ls_addr_i;
    logic [WIDTH-1:0]      ls_wdata_i;
    logic                  ls_gnt_o;
    logic                  ls_rvalid_o;
    logic [WIDTH-1:0]      ls_rdata_o;
    logic                  ls_err_o;
    logic                  memread_o;
    logic                  memwrite_o;
    logic [ADDR_WIDTH-1:0] memaddr_o;
    logic [WIDTH-1:0]      memwdata_o;
    logic [WIDTH-1:0]      memrdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output memread_o, memwrite_o, memaddr_o, memwdata_o,
        input  memrdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  memread_o, memwrite_o, memaddr_o, memwdata_o,
        output memrdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and load/store, 1-cycle read latency.
// Define ARB_FAIR_EN to add the MAX_WAIT fetch-starvation override.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    logic fair_win;
    logic ls_win;
    logic if_win;
    logic ls_mis;
    logic ls_acc;
    logic pend_if;
    logic pend_ls;
    logic err_q;

    assign ls_mis = bus.ls_addr_i[1:0] != 2'b00;
    assign ls_win = rst & bus.ls_req_i & ~fair_win;
    assign if_win = rst & bus.if_req_i & ~ls_win;
    assign ls_acc = ls_win & ~ls_mis;

`ifdef ARB_FAIR_EN
    logic [3:0] wait_cnt;

    assign fair_win = bus.if_req_i & (wait_cnt == 4'(MAX_WAIT));

    // Saturate so a lingering denial never wraps back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (!bus.if_req_i || if_win) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hf) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign fair_win = 1'b0;
`endif

    assign bus.if_gnt_o   = if_win;
    assign bus.ls_gnt_o   = ls_win;
    assign bus.memread_o  = if_win | (ls_acc & ~bus.ls_we_i);
    assign bus.memwrite_o = ls_acc & bus.ls_we_i;
    assign bus.memaddr_o  = if_win ? bus.if_addr_i :
                            ls_acc ? bus.ls_addr_i : '0;
    assign bus.memwdata_o = (ls_acc & bus.ls_we_i) ? bus.ls_wdata_i : '0;

    // One-entry pending slot, rewritten every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_if <= 1'b0;
            pend_ls <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend_if <= if_win;
            pend_ls <= ls_acc & ~bus.ls_we_i;
            err_q   <= ls_win & ls_mis;
        end
    end

    assign bus.if_rvalid_o = rst & pend_if;
    assign bus.ls_rvalid_o = rst & pend_ls;
    assign bus.ls_err_o    = rst & err_q;
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.memrdata_i : '0;
    assign bus.ls_rdata_o  = bus.ls_rvalid_o ? bus.memrdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus reset and
// fairness sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_arbiter #(
        .WIDTH(32),
        .ADDR_WIDTH(32),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // flags: {if_gnt, ls_gnt, memread, memwrite, ls_err, if_rvalid, ls_rvalid}
    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [31:0] mrd;
        logic [6:0]  fl;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] ifrd;
        logic [31:0] lsrd;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic lr, input logic lw,
        input logic [31:0] la, input logic [31:0] ld,
        input logic [31:0] mr, input logic [6:0] fl,
        input logic [31:0] ma, input logic [31:0] mw,
        input logic [31:0] ird, input logic [31:0] lrd);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;
        v.ls_req = lr;  v.ls_we = lw;
        v.ls_addr = la; v.ls_wdata = ld;
        v.mrd = mr;     v.fl = fl;
        v.maddr = ma;   v.mwdata = mw;
        v.ifrd = ird;   v.lsrd = lrd;
        return v;
    endfunction

    function automatic logic [134:0] outs();
        return {bus.if_gnt_o, bus.ls_gnt_o, bus.memread_o,
                bus.memwrite_o, bus.ls_err_o, bus.if_rvalid_o,
                bus.ls_rvalid_o, bus.memaddr_o, bus.memwdata_o,
                bus.if_rdata_o, bus.ls_rdata_o};
    endfunction

    task automatic check(input string name, input logic [134:0] act,
                         input logic [134:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic lr, input logic lw,
                         input logic [31:0] la, input logic [31:0] ld,
                         input logic [31:0] mr);
        bus.if_req_i   = ir;
        bus.if_addr_i  = ia;
        bus.ls_req_i   = lr;
        bus.ls_we_i    = lw;
        bus.ls_addr_i  = la;
        bus.ls_wdata_i = ld;
        bus.memrdata_i = mr;
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] g_exp;
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,
                     7'b0000000, 0, 0, 0, 0);
        tbl[1]  = mk(1, 32'h10, 0, 0, 0, 0, 0,
                     7'b1010000, 32'h10, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 32'hdeadbeef,
                     7'b0000010, 0, 0, 32'hdeadbeef, 0);
        tbl[3]  = mk(1, 32'h20, 1, 0, 32'h1004, 0, 0,
                     7'b0110000, 32'h1004, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 32'h11112222,
                     7'b0000001, 0, 0, 0, 32'h11112222);
        tbl[5]  = mk(0, 0, 1, 1, 32'h1002, 32'haaaa, 0,
                     7'b0100000, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,
                     7'b0000100, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,
                     7'b0000000, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 1, 1, 32'h2000, 32'h12345678, 0,
                     7'b0101000, 32'h2000, 32'h12345678, 0, 0);
        tbl[9]  = mk(1, 32'h30, 0, 0, 0, 0, 32'h55,
                     7'b1010000, 32'h30, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 32'h40, 0, 32'h99,
                     7'b0110010, 32'h40, 0, 32'h99, 0);
        tbl[11] = mk(1, 32'h44, 0, 0, 0, 0, 32'h77,
                     7'b1010001, 32'h44, 0, 0, 32'h77);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 32'h88,
                     7'b0000010, 0, 0, 32'h88, 0);
        tbl[13] = mk(1, 32'h50, 1, 0, 32'h1001, 0, 0,
                     7'b0100000, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 32'h33,
                     7'b0000100, 0, 0, 0, 0);

        // Outputs held at zero during reset even with requests present.
        drive(1, 32'h10, 1, 1, 32'h2000, 32'hffff, 32'h1234);
        #12;
        check("reset_state", outs(), '0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].ls_req,
                  tbl[i].ls_we, tbl[i].ls_addr, tbl[i].ls_wdata,
                  tbl[i].mrd);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].fl, tbl[i].maddr, tbl[i].mwdata,
                   tbl[i].ifrd, tbl[i].lsrd});
        end

        // Alternating reads, then reset asserted mid-stream.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive(i % 2 == 0, 32'h100, i % 2 == 1, 0, 32'h200, 0,
                  32'hc0de0000 + i);
            @(negedge clk);
            check($sformatf("alt%0d", i), outs(),
                  {(i % 2 == 0), (i % 2 == 1), 1'b1, 4'b0000,
                   (i % 2 == 0) ? 32'h100 : 32'h200, 32'h0,
                   32'h0, 32'h0} |
                  ((i == 0) ? '0 :
                   (i % 2 == 1) ? {5'b0, 1'b1, 1'b0, 64'h0,
                                   32'hc0de0000 + i, 32'h0}
                                : {5'b0, 1'b0, 1'b1, 64'h0,
                                   32'h0, 32'hc0de0000 + i}));
        end
        @(posedge clk);
        #1;
        drive(1, 32'h100, 0, 0, 0, 0, 32'h5a5a);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_stream", outs(), '0);
        @(negedge clk);
        check("rst_held", outs(), '0);
        drive(0, 0, 0, 0, 0, 0, 32'h6b6b);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("no_rvalid_after_release", outs(), '0);
        drive(1, 32'h60, 0, 0, 0, 0, 0);
        #1;
        check("first_grant", outs(),
              {7'b1010000, 32'h60, 96'h0});
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 32'h7c7c);
        @(negedge clk);
        check("first_grant_rvalid", outs(),
              {7'b0000010, 64'h0, 32'h7c7c, 32'h0});

        // Continuous contention: LS load versus IF fetch.
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            drive(1, 32'h300, 1, 0, 32'h400, 0, 0);
            @(negedge clk);
            g = {bus.if_gnt_o, bus.ls_gnt_o};
`ifdef ARB_FAIR_EN
            g_exp = (i % 5 == 4) ? 2'b10 : 2'b01;
`else
            g_exp = 2'b01;
`endif
            check($sformatf("contend%0d", i), {133'h0, g},
                  {133'h0, g_exp});
        end
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data width in bits.
REQ-002 Parameter: ADDR_WIDTH, 32, byte address width in bits.
REQ-003 Parameter: MAX_WAIT, 4, consecutive IF denials before IF is forced to win (range 1..15).
REQ-004 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req_i  in  1  fetch read request.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  WIDTH  fetch read data.
- ls_req_i  in  1  load/store request.
- ls_we_i  in  1  1 = store, 0 = load.
- ls_addr_i  in  ADDR_WIDTH  load/store byte address.
- ls_wdata_i  in  WIDTH  store data.
- ls_gnt_o  out  1  load/store request accepted or rejected this cycle.
- ls_rvalid_o  out  1  load data valid.
- ls_rdata_o  out  WIDTH  load data.
- ls_err_o  out  1  misaligned-access error pulse.
- memread_o  out  1  read strobe to memory.
- memwrite_o  out  1  write strobe to memory.
- memaddr_o  out  ADDR_WIDTH  memory address.
- memwdata_o  out  WIDTH  memory write data.
- memrdata_i  in  WIDTH  memory read data, valid one cycle after the address is presented.

Function
REQ-005 At most one grant SHALL be issued per cycle; grants and mem* outputs are combinational from requests and state.
REQ-006 With the fairness override inactive, LS SHALL have priority over IF when both request.
REQ-007 LS grant with ls_addr_i[1:0] != 0 SHALL NOT drive memread_o/memwrite_o; ls_err_o SHALL pulse high for exactly one cycle, on the cycle after the grant.
REQ-008 Aligned LS store grant: memwrite_o=1, memaddr_o=ls_addr_i, memwdata_o=ls_wdata_i; no rvalid is produced.
REQ-009 Aligned LS load or IF grant: memread_o=1, memaddr_o=requester address; the owner (IF/LS) is registered into a one-entry pending slot.
REQ-010 The cycle after a read grant, the owner's rvalid SHALL be 1 with rdata=memrdata_i; the other rvalid SHALL be 0; the read latency is exactly 1.
REQ-011 Back-to-back reads (including alternating owners) SHALL be issued every cycle without bubbles; the pending slot is overwritten each cycle.
REQ-012 With no grant, memread_o, memwrite_o, memaddr_o and memwdata_o SHALL be 0.
REQ-013 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.

Reset
REQ-014 While rst=0: all grants, mem* outputs, rvalid, rdata and ls_err_o SHALL be 0; the pending slot and wait counter SHALL be cleared asynchronously.
REQ-015 A read granted in the cycle before reset assertion SHALL produce no rvalid after reset release.
REQ-016 The first grant SHALL be possible in the first rising edge cycle with rst=1.

Configuration
REQ-017 Macro ARB_FAIR_EN defined: a 4-bit wait counter SHALL increment on each cycle with if_req_i=1 and if_gnt_o=0.
- The counter clears on an IF grant or when if_req_i=0.
- When the counter equals MAX_WAIT, IF SHALL win over LS for that cycle.
REQ-018 Macro ARB_FAIR_EN undefined: no counter SHALL exist and priority is fixed LS over IF.

Verification
REQ-019 IF read of 0x0000_0010 alone, memrdata_i=0xDEAD_BEEF next cycle -> if_gnt_o=1 and memread_o=1 in cycle N; if_rvalid_o=1 and if_rdata_o=0xDEAD_BEEF in cycle N+1.
REQ-020 IF and LS load (0x1004) requested in the same cycle -> ls_gnt_o=1, if_gnt_o=0, memaddr_o=0x1004; ls_rvalid_o=1 next cycle.
REQ-021 LS store to 0x1002 -> ls_gnt_o=1, memwrite_o=0, ls_err_o=1 exactly one cycle later.
REQ-022 With ARB_FAIR_EN defined and MAX_WAIT=4, IF and LS both requesting continuously -> LS granted 4 cycles, IF granted on the 5th cycle, pattern repeats; with the macro undefined, IF is never granted.
REQ-023 Alternating IF/LS reads every cycle, then rst=0 asserted mid-stream -> all outputs 0 immediately; no rvalid after release.
